// File: rtl/debounce_pulse.sv
// ----------------------------------------------------------------------------
// debounce_pulse
//   Conditions one raw, bouncy, asynchronous pushbutton for the lab datapath.
//   The input is brought into the clk domain through a two-flop synchroniser.
//   A four-state FSM with a stability counter then accepts a new level only
//   after the synchronised input has held that level for DB_COUNT+1
//   consecutive rising edges: the entry edge plus DB_COUNT counting edges.
//   Each accepted change produces one single-cycle strobe, so downstream
//   counters and FSMs see exactly one event per physical press or release.
//
//   Parameters
//     DB_COUNT  consecutive stable clocks required (>= 1)
//     CNT_W     stability counter width, DB_COUNT <= 2**CNT_W - 1
//
//   Ports
//     clk        in   system clock, all state on the rising edge
//     rst        in   asynchronous active-high reset (already synchronised
//                     upstream, so its release is clean in this domain)
//     btn_in     in   raw pushbutton, active-high, asynchronous to clk
//     btn_level  out  debounced button level, registered
//     btn_pulse  out  one-clock strobe on a debounced press (0->1)
//     btn_rel    out  one-clock strobe on a debounced release (1->0)
// ----------------------------------------------------------------------------
module debounce_pulse #(
  parameter int DB_COUNT = 1000000,
  parameter int CNT_W    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_rel
);

  // Every 2-bit code is a named state. The default arm in the next-state
  // logic still recovers to IDLE_LO if the encoding is ever widened.
  localparam logic [1:0] IDLE_LO   = 2'b00;
  localparam logic [1:0] WAIT_HI   = 2'b01;
  localparam logic [1:0] STABLE_HI = 2'b10;
  localparam logic [1:0] WAIT_LO   = 2'b11;

  // The terminal count is compared exactly. The counter stops there and
  // never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s0_q;
  logic             btn_s_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             rel_q;
  logic             rel_d;

  // ---- stage 0/1: two-flop synchroniser; only btn_s_q is used downstream ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      s0_q    <= btn_in;
      btn_s_q <= s0_q;
    end
  end

  // ---- stage 2: debounce FSM next-state and output decode ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (btn_s_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!btn_s_q) begin
          // A bounce back to low abandons the attempt without any output change.
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!btn_s_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (btn_s_q) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // ---- stage 3: FSM state and registered outputs ----
  // Reset discards any debounce in progress. Strobes are cleared here, so
  // neither the assertion nor the release of rst can create an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign btn_rel   = rel_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// ----------------------------------------------------------------------------
// tb_debounce_pulse
//   Bench for debounce_pulse with DB_COUNT=4 and CNT_W=3. It applies a table
//   of vectors for a clean press and release, then hand-written sequences for
//   bounce, glitch, release glitch, reset during a debounce and a long hold,
//   then randomised run-length stimulus. Every cycle it also compares the DUT
//   against a run-length reference model.
// ----------------------------------------------------------------------------
module tb_debounce_pulse;

  localparam int DB = 4;
  localparam int CW = 3;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;
  logic btn_rel;

  int checks = 0;
  int fails  = 0;

  debounce_pulse #(.DB_COUNT(DB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .btn_rel   (btn_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a new level is accepted once the synchronised input has
  // disagreed with the current level on DB+1 consecutive edges.
  logic [1:0] m_sync;
  int         m_run;
  logic       m_level;
  logic       m_pulse;
  logic       m_rel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync  <= 2'b00;
      m_run   <= 0;
      m_level <= 1'b0;
      m_pulse <= 1'b0;
      m_rel   <= 1'b0;
    end else begin
      m_sync  <= {m_sync[0], btn_in};
      m_pulse <= 1'b0;
      m_rel   <= 1'b0;
      if (m_sync[1] == m_level) begin
        m_run <= 0;
      end else if (m_run == DB) begin
        m_run   <= 0;
        m_level <= ~m_level;
        m_pulse <= ~m_level;
        m_rel   <= m_level;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Strobe ordering: after reset the next strobe must be a press.
  bit next_is_press = 1'b1;
  int n_pulse = 0;
  int n_rel   = 0;

  // Apply one input value across one rising edge, then sample at the
  // following falling edge.
  task automatic cyc(input logic b);
    btn_in = b;
    @(posedge clk);
    @(negedge clk);
    chk("model_level", btn_level, m_level);
    chk("model_pulse", btn_pulse, m_pulse);
    chk("model_rel",   btn_rel,   m_rel);
    chk("strobe_excl", btn_pulse & btn_rel, 1'b0);
    if (rst) next_is_press = 1'b1;
    if (btn_pulse) begin
      n_pulse++;
      chk("press_order", next_is_press, 1'b1);
      next_is_press = 1'b0;
    end
    if (btn_rel) begin
      n_rel++;
      chk("release_order", next_is_press, 1'b0);
      next_is_press = 1'b1;
    end
  endtask

  typedef struct {
    logic btn;
    logic lvl;
    logic pls;
    logic rel;
  } vec_t;

  vec_t vt[30];

  initial begin
    logic b;
    int   len;

    // Clean press of 20 clocks, then release. Edges are counted from the
    // first edge that samples the change: strobe and level change at edge 7.
    for (int k = 0; k < 30; k++) begin
      vt[k].btn = (k < 20);
      vt[k].lvl = (k >= 6) && (k < 26);
      vt[k].pls = (k == 6);
      vt[k].rel = (k == 26);
    end

    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_level", btn_level, 1'b0);
    chk("reset_pulse", btn_pulse, 1'b0);
    chk("reset_rel",   btn_rel,   1'b0);
    rst = 1'b0;

    for (int k = 0; k < 30; k++) begin
      cyc(vt[k].btn);
      chk("tbl_level", btn_level, vt[k].lvl);
      chk("tbl_pulse", btn_pulse, vt[k].pls);
      chk("tbl_rel",   btn_rel,   vt[k].rel);
    end

    // Bounce: high 3, low 2, then held high. Pulse 7 edges after the final rise.
    for (int k = 0; k < 20; k++) begin
      cyc((k < 3) || (k >= 5));
      chk("bounce_pulse", btn_pulse, k == 11);
      chk("bounce_level", btn_level, k >= 11);
      chk("bounce_rel",   btn_rel,   1'b0);
    end

    // One-clock low glitch while stable high: no release, level stays high.
    for (int k = 0; k < 20; k++) begin
      cyc(k != 0);
      chk("relglitch_level", btn_level, 1'b1);
      chk("relglitch_rel",   btn_rel,   1'b0);
      chk("relglitch_pulse", btn_pulse, 1'b0);
    end

    // Genuine release held low.
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0);
      chk("release_rel",   btn_rel,   k == 6);
      chk("release_level", btn_level, k < 6);
    end

    // Single-clock high glitch from idle: every output stays low.
    for (int k = 0; k < 20; k++) begin
      cyc(k == 0);
      chk("glitch_level", btn_level, 1'b0);
      chk("glitch_pulse", btn_pulse, 1'b0);
      chk("glitch_rel",   btn_rel,   1'b0);
    end

    // Reset while the counter sits at 2 in WAIT_HI, with the button held.
    for (int k = 0; k < 5; k++) cyc(1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_level", btn_level, 1'b0);
    chk("rstmid_pulse", btn_pulse, 1'b0);
    chk("rstmid_rel",   btn_rel,   1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1);
      chk("inrst_pulse", btn_pulse, 1'b0);
      chk("inrst_level", btn_level, 1'b0);
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc(1'b1);
      chk("postrst_pulse", btn_pulse, k == 6);
      chk("postrst_level", btn_level, k >= 6);
      chk("postrst_rel",   btn_rel,   1'b0);
    end
    for (int k = 0; k < 12; k++) cyc(1'b0);

    // Long hold: exactly one press and one release strobe over the run.
    n_pulse = 0;
    n_rel   = 0;
    for (int k = 0; k < 100; k++) cyc(1'b1);
    for (int k = 0; k < 20; k++)  cyc(1'b0);
    checks++;
    if (n_pulse != 1) begin
      fails++;
      $display("FAIL longhold_pulses: got %0d, expected 1", n_pulse);
    end
    checks++;
    if (n_rel != 1) begin
      fails++;
      $display("FAIL longhold_releases: got %0d, expected 1", n_rel);
    end

    // Random run-length stimulus; runs of 1..9 clocks straddle the
    // acceptance length, so both rejections and acceptances occur.
    b = 1'b0;
    for (int r = 0; r < 250; r++) begin
      b   = ~b;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) cyc(b);
    end
    for (int k = 0; k < 12; k++) cyc(1'b0);
    chk("final_level", btn_level, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
